// File: rtl/aq_fifo_pkg.sv
// rtl/aq_fifo_pkg.sv - shared constants and helpers for the aq_fifo_sync FIFO
package aq_fifo_pkg;

  localparam string MODE_FWFT = "TRUE";
  localparam string MODE_STD  = "FALSE";

  // Occupancy needs one extra bit so that COUNT can reach DEPTH itself.
  function automatic int unsigned clog2_cnt(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic at_or_above(input int unsigned level, input int unsigned thresh);
    return level >= thresh;
  endfunction

  function automatic logic at_or_below(input int unsigned level, input int unsigned thresh);
    return level <= thresh;
  endfunction

endpackage

// File: rtl/aq_fifo_ram.sv
// rtl/aq_fifo_ram.sv - simple dual-port storage array with one-cycle registered read
module aq_fifo_ram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is cleared; the array keeps stale contents.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/aq_fifo_sync.sv
// rtl/aq_fifo_sync.sv - single-clock FIFO with standard/FWFT read, thresholds and reset-busy window
module aq_fifo_sync
  import aq_fifo_pkg::*;
#(
  parameter int unsigned WIDTH             = 64,
  parameter int unsigned DEPTH             = 512,
  parameter string       FWFT              = "TRUE",
  parameter int unsigned PROG_FULL_THRESH  = 256,
  parameter int unsigned PROG_EMPTY_THRESH = 128,
  parameter int unsigned RST_BUSY_CYCLES   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic                         RSTBUSY,
  input  logic                         WREN,
  input  logic [WIDTH-1:0]             DIN,
  output logic                         FULL,
  output logic                         PROGFULL,
  output logic                         WRERR,
  input  logic                         RDEN,
  output logic [WIDTH-1:0]             DOUT,
  output logic                         EMPTY,
  output logic                         PROGEMPTY,
  output logic                         RDERR,
  output logic [clog2_cnt(DEPTH)-1:0]  COUNT
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = clog2_cnt(DEPTH);
  localparam int unsigned BW      = $clog2(RST_BUSY_CYCLES + 1);
  localparam bit          IS_FWFT = (FWFT == MODE_FWFT);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic [BW-1:0]    busy_cnt;
  logic             wr_acc, rd_acc, fetch, empty_d;
  logic [WIDTH-1:0] ram_rdata;

  assign wr_acc  = WREN & !FULL & !RSTBUSY;
  assign count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
  assign COUNT   = count_q;

  aq_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (DIN),
    .rd_en   (fetch),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  generate
    if (IS_FWFT) begin : g_fwft
      // Two-stage prefetch: RAM read register, then the DOUT register.
      logic [CW-1:0]    mem_cnt;
      logic             ram_valid, dout_valid, load_out;
      logic [WIDTH-1:0] dout_q;

      assign rd_acc   = RDEN & dout_valid & !RSTBUSY;
      assign load_out = ram_valid & (!dout_valid | rd_acc);
      assign fetch    = (mem_cnt != '0) & (!ram_valid | load_out);
      assign empty_d  = !(load_out | (dout_valid & !rd_acc));
      assign DOUT     = dout_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          mem_cnt    <= '0;
          ram_valid  <= 1'b0;
          dout_valid <= 1'b0;
          dout_q     <= '0;
        end else begin
          mem_cnt <= mem_cnt + CW'(wr_acc) - CW'(fetch);
          if (fetch)         ram_valid <= 1'b1;
          else if (load_out) ram_valid <= 1'b0;
          if (load_out) begin
            dout_valid <= 1'b1;
            dout_q     <= ram_rdata;
          end else if (rd_acc) begin
            dout_valid <= 1'b0;
          end
        end
      end
    end else begin : g_std
      assign rd_acc  = RDEN & !EMPTY & !RSTBUSY;
      assign fetch   = rd_acc;
      assign empty_d = (count_d == '0);
      assign DOUT    = ram_rdata;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      FULL      <= 1'b0;
      PROGFULL  <= 1'b0;
      EMPTY     <= 1'b1;
      PROGEMPTY <= 1'b1;
      WRERR     <= 1'b0;
      RDERR     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)  rd_ptr <= rd_ptr + 1'b1;
      count_q   <= count_d;
      FULL      <= (count_d == CW'(DEPTH));
      PROGFULL  <= at_or_above(32'(count_d), PROG_FULL_THRESH);
      PROGEMPTY <= at_or_below(32'(count_d), PROG_EMPTY_THRESH);
      EMPTY     <= empty_d;
      WRERR     <= WREN & FULL & !RSTBUSY;
      RDERR     <= RDEN & EMPTY & !RSTBUSY;
    end
  end

  // Busy stays high while RST is held and for RST_BUSY_CYCLES edges afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_cnt <= BW'(RST_BUSY_CYCLES);
      RSTBUSY  <= 1'b1;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
      RSTBUSY  <= (busy_cnt != BW'(1));
    end
  end

endmodule

// File: tb/tb_aq_fifo_sync.sv
// tb/tb_aq_fifo_sync.sv - directed self-checking bench for aq_fifo_sync (FWFT and standard instances)
module tb_aq_fifo_sync;

  localparam logic [63:0] BASE = 64'hFEDCBA98_76543210;
  localparam logic [63:0] PAT  = 64'hA5A5_0000_0000_0000;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  logic        f_wren = 1'b0, f_rden = 1'b0;
  logic [63:0] f_din  = '0;
  logic        f_rstbusy, f_full, f_progfull, f_wrerr, f_empty, f_progempty, f_rderr;
  logic [63:0] f_dout;
  logic [9:0]  f_count;

  logic        s_wren = 1'b0, s_rden = 1'b0;
  logic [63:0] s_din  = '0;
  logic        s_rstbusy, s_full, s_progfull, s_wrerr, s_empty, s_progempty, s_rderr;
  logic [63:0] s_dout;
  logic [9:0]  s_count;

  aq_fifo_sync #(
    .WIDTH(64), .DEPTH(512), .FWFT(aq_fifo_pkg::MODE_FWFT),
    .PROG_FULL_THRESH(256), .PROG_EMPTY_THRESH(128), .RST_BUSY_CYCLES(4)
  ) dut_f (
    .CLK(clk), .RST(rst), .RSTBUSY(f_rstbusy),
    .WREN(f_wren), .DIN(f_din), .FULL(f_full), .PROGFULL(f_progfull), .WRERR(f_wrerr),
    .RDEN(f_rden), .DOUT(f_dout), .EMPTY(f_empty), .PROGEMPTY(f_progempty), .RDERR(f_rderr),
    .COUNT(f_count)
  );

  aq_fifo_sync #(
    .WIDTH(64), .DEPTH(512), .FWFT(aq_fifo_pkg::MODE_STD),
    .PROG_FULL_THRESH(256), .PROG_EMPTY_THRESH(128), .RST_BUSY_CYCLES(4)
  ) dut_s (
    .CLK(clk), .RST(rst), .RSTBUSY(s_rstbusy),
    .WREN(s_wren), .DIN(s_din), .FULL(s_full), .PROGFULL(s_progfull), .WRERR(s_wrerr),
    .RDEN(s_rden), .DOUT(s_dout), .EMPTY(s_empty), .PROGEMPTY(s_progempty), .RDERR(s_rderr),
    .COUNT(s_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with WREN held, then the busy window
    f_wren = 1'b1;
    f_din  = 64'h1;
    for (int i = 0; i < 10; i++) tick();
    check("rst_busy",      64'(f_rstbusy),   64'd1);
    check("rst_count",     64'(f_count),     64'd0);
    check("rst_empty",     64'(f_empty),     64'd1);
    check("rst_progempty", 64'(f_progempty), 64'd1);
    check("rst_full",      64'(f_full),      64'd0);
    check("rst_progfull",  64'(f_progfull),  64'd0);
    check("rst_dout",      f_dout,           64'd0);
    check("rst_s_empty",   64'(s_empty),     64'd1);
    check("rst_s_dout",    s_dout,           64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("busy_window", 64'(f_rstbusy), (i < 4) ? 64'd1 : 64'd0);
      check("busy_count",  64'(f_count),   64'd0);
      check("busy_wrerr",  64'(f_wrerr),   64'd0);
    end
    f_wren = 1'b0;
    tick();
    check("post_busy_count", 64'(f_count), 64'd0);

    // 2: fill to 512 and watch every flag boundary
    f_wren = 1'b1;
    for (int i = 0; i < 512; i++) begin
      f_din = BASE + 64'(i);
      tick();
      check("fill_count",     64'(f_count),     64'(i + 1));
      check("fill_progempty", 64'(f_progempty), (i + 1 <= 128) ? 64'd1 : 64'd0);
      check("fill_progfull",  64'(f_progfull),  (i + 1 >= 256) ? 64'd1 : 64'd0);
      check("fill_full",      64'(f_full),      (i + 1 == 512) ? 64'd1 : 64'd0);
      check("fill_empty",     64'(f_empty),     (i < 2) ? 64'd1 : 64'd0);
    end
    check("fill_head", f_dout, BASE);
    f_din = 64'hDEAD;
    tick();
    check("overflow_wrerr", 64'(f_wrerr), 64'd1);
    check("overflow_count", 64'(f_count), 64'd512);
    f_wren = 1'b0;
    tick();
    check("overflow_wrerr_clear", 64'(f_wrerr), 64'd0);

    // 3: drain at full rate, one word per cycle
    f_rden = 1'b1;
    for (int j = 0; j < 512; j++) begin
      check("drain_dout",  f_dout,          BASE + 64'(j));
      check("drain_empty", 64'(f_empty),    64'd0);
      check("drain_count", 64'(f_count),    64'(512 - j));
      tick();
    end
    check("drained_empty", 64'(f_empty), 64'd1);
    check("drained_count", 64'(f_count), 64'd0);
    tick();
    check("underflow_rderr", 64'(f_rderr), 64'd1);
    f_rden = 1'b0;
    tick();
    check("underflow_rderr_clear", 64'(f_rderr), 64'd0);

    // 5: hold 300 words with simultaneous write/read across pointer wrap
    f_wren = 1'b1;
    for (int k = 0; k < 300; k++) begin
      f_din = PAT + 64'(k);
      tick();
    end
    f_wren = 1'b0;
    tick();
    check("hold_count", 64'(f_count), 64'd300);
    check("hold_progfull", 64'(f_progfull), 64'd1);
    f_wren = 1'b1;
    f_rden = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      check("stream_dout",  f_dout,       PAT + 64'(j));
      check("stream_count", 64'(f_count), 64'd300);
      f_din = PAT + 64'(300 + j);
      tick();
    end
    f_rden = 1'b0;

    // 6: full with simultaneous WREN+RDEN, then reset mid-operation
    for (int k = 0; k < 212; k++) begin
      f_din = PAT + 64'(1300 + k);
      tick();
    end
    check("refill_full", 64'(f_full), 64'd1);
    f_din  = 64'hBAD;
    f_rden = 1'b1;
    tick();
    check("full_rw_count", 64'(f_count), 64'd511);
    check("full_rw_wrerr", 64'(f_wrerr), 64'd1);
    check("full_rw_dout",  f_dout,       PAT + 64'd1001);
    f_wren = 1'b0;
    for (int k = 0; k < 311; k++) tick();
    f_rden = 1'b0;
    check("pre_rst_count", 64'(f_count), 64'd200);
    rst = 1'b1;
    tick();
    check("midrst_count", 64'(f_count),   64'd0);
    check("midrst_empty", 64'(f_empty),   64'd1);
    check("midrst_dout",  f_dout,         64'd0);
    check("midrst_busy",  64'(f_rstbusy), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 4: standard read mode latency
    s_wren = 1'b1;
    s_din  = BASE;
    tick();
    check("std_count_wr", 64'(s_count), 64'd1);
    check("std_empty_wr", 64'(s_empty), 64'd0);
    check("std_dout_pre", s_dout,       64'd0);
    s_wren = 1'b0;
    s_rden = 1'b1;
    tick();
    check("std_dout",     s_dout,       BASE);
    check("std_count_rd", 64'(s_count), 64'd0);
    check("std_empty_rd", 64'(s_empty), 64'd1);
    s_rden = 1'b0;
    tick();
    check("std_dout_hold", s_dout, BASE);
    s_rden = 1'b1;
    tick();
    check("std_rderr",      64'(s_rderr), 64'd1);
    check("std_dout_hold2", s_dout,       BASE);
    s_rden = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
